counter_period_capture_pipeline: RTL

Pipelined interval-measurement counter. It counts enabled clock ticks between successive event pulses and reports each interval as a resolved binary value with a one-cycle valid. It is the receive-side counterpart of the strobe-divider counters: a strobe train from a divider programmed with N reads back as N. The counter is split into LUT_SIZE-bit chunks with registered carries, and the capture path resolves those carries over a short pipeline so the increment logic holds fmax at any WIDTH.

---
 rtl/counter_pkg.sv | 14 +
 rtl/counter_chunk_resolve.sv | 12 +
 rtl/counter_period_capture_pipeline.sv | 111 +++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: sizing helpers and chunk state shared by the chunked counters
package counter_pkg;
   localparam int LUT_SIZE_DEFAULT = 4;
   typedef struct packed {
      logic                        carry;
      logic [LUT_SIZE_DEFAULT-1:0] value;
   } chunk_t;
   function automatic int chunk_count(input int width, input int lut);
      return (width + lut - 1) / lut;
   endfunction
   function automatic int last_chunk_size(input int width, input int lut);
      return (width % lut == 0) ? lut : width % lut;
   endfunction
endpackage

// File: rtl/counter_chunk_resolve.sv
// counter_chunk_resolve: one registered chunk adder of the carry-resolution pipeline
module counter_chunk_resolve #(
   parameter int LUT_SIZE = 4
) (
   input  logic                clk,
   input  logic [LUT_SIZE-1:0] value_in,
   input  logic                carry_in,
   output logic [LUT_SIZE-1:0] value_out,
   output logic                carry_out
);
   always_ff @(posedge clk) {carry_out, value_out} <= {1'b0, value_in} + (LUT_SIZE+1)'(carry_in);
endmodule

// File: rtl/counter_period_capture_pipeline.sv
// counter_period_capture_pipeline: chunked interval counter whose captured carries
// are resolved one chunk per stage before the period is reported
module counter_period_capture_pipeline
   import counter_pkg::*;
#(
   parameter int WIDTH    = 15,
   parameter int LUT_SIZE = LUT_SIZE_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             event_in,
   output logic [WIDTH-1:0] period,
   output logic             valid,
   output logic             overflow,
   output logic             armed
);
   localparam int N  = chunk_count(WIDTH, LUT_SIZE);
   localparam int LC = last_chunk_size(WIDTH, LUT_SIZE);
   localparam int LB = (N - 1) * LUT_SIZE;
   localparam int NR = (N > 1) ? N - 1 : 1;
   localparam logic [WIDTH-1:0] TOP_MASK = {WIDTH{1'b1}} << LB;

   logic [WIDTH-1:0]    cnt, cnt_nx;
   logic [N-1:0]        cy, cout;
   logic [N:0]          cin;
   logic                ovf_acc, accept;
   logic [N-1:0]        st_val, st_ovf;
   logic [WIDTH-1:0]    st_cnt [N];
   logic [WIDTH-1:0]    eff_cnt [N];
   logic [N:0]          st_pend [N];
   logic [N:0]          eff_pend [N];
   logic [LUT_SIZE-1:0] res_val [NR];
   logic [NR-1:0]       res_cy;
   logic [LC-1:0]       fin_val;
   logic                fin_cy, ovf_f;
   logic [WIDTH-1:0]    per_f;

   assign accept = enable & event_in;
   // bit i is the carry entering chunk i; bit N is a carry out of the whole counter
   assign cin    = {cy, enable};

   for (genvar i = 0; i < N; i++) begin : g_cnt
      localparam int CW = (i == N - 1) ? LC : LUT_SIZE;
      assign {cout[i], cnt_nx[i*LUT_SIZE +: CW]} = {1'b0, cnt[i*LUT_SIZE +: CW]} + (CW+1)'(cin[i]);
   end

   for (genvar s = 0; s < N; s++) begin : g_st
      if (s == 0) begin : g_head
         assign eff_cnt[0]  = st_cnt[0];
         assign eff_pend[0] = st_pend[0];
      end else begin : g_fold
         localparam logic [WIDTH-1:0] M = WIDTH'({LUT_SIZE{1'b1}}) << ((s - 1) * LUT_SIZE);
         assign eff_cnt[s]  = (st_cnt[s] & ~M) | (WIDTH'(res_val[s-1]) << ((s - 1) * LUT_SIZE));
         assign eff_pend[s] = st_pend[s] | ((N+1)'(res_cy[s-1]) << s);
      end
      if (s < N - 1) begin : g_res
         counter_chunk_resolve #(.LUT_SIZE(LUT_SIZE)) u_res (
            .clk       (clk),
            .value_in  (eff_cnt[s][s*LUT_SIZE +: LUT_SIZE]),
            .carry_in  (eff_pend[s][s]),
            .value_out (res_val[s]),
            .carry_out (res_cy[s])
         );
      end
   end

   assign {fin_cy, fin_val} = {1'b0, eff_cnt[N-1][LB +: LC]} + (LC+1)'(eff_pend[N-1][N-1]);
   assign per_f = (eff_cnt[N-1] & ~TOP_MASK) | (WIDTH'(fin_val) << LB);
   assign ovf_f = st_ovf[N-1] | fin_cy | eff_pend[N-1][N];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt      <= '0;
         cy       <= '0;
         ovf_acc  <= 1'b0;
         armed    <= 1'b0;
         st_val   <= '0;
         valid    <= 1'b0;
         overflow <= 1'b0;
         period   <= '0;
      end else begin
         if (accept) begin
            cnt     <= '0;
            cy      <= '0;
            ovf_acc <= 1'b0;
            armed   <= 1'b1;
         end else begin
            cnt     <= cnt_nx;
            cy      <= cout;
            ovf_acc <= ovf_acc | cout[N-1];
         end
         // the first event only establishes the reference point
         st_val[0]  <= accept & armed;
         st_ovf[0]  <= ovf_acc;
         st_cnt[0]  <= cnt;
         st_pend[0] <= cin;
         for (int s = 1; s < N; s++) begin
            st_val[s]  <= st_val[s-1];
            st_ovf[s]  <= st_ovf[s-1];
            st_cnt[s]  <= eff_cnt[s-1];
            st_pend[s] <= eff_pend[s-1];
         end
         valid <= st_val[N-1];
         if (st_val[N-1]) begin
            overflow <= ovf_f;
            period   <= ovf_f ? '1 : per_f;
         end
      end
   end
endmodule
